query_patch_loader: RTL and testbench

// - Upstream stage of the query patch memory. Accepts query-image pixels one per beat over a

---
 rtl/query_pkg.sv | 22 ++
 rtl/query_patch_loader_packer.sv | 56 +++++
 rtl/query_patch_loader.sv | 82 ++++++++
 tb/tb_query_patch_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/query_pkg.sv
// Shared constants and types for the query patch memory path.
// Pixel k of a patch lives at bits [k*DATA_WIDTH +: DATA_WIDTH] of patch_t.
package query_pkg;

   localparam int DATA_WIDTH  = 11;
   localparam int PATCH_SIZE  = 5;
   localparam int ADDR_WIDTH  = 9;
   localparam int NUM_PATCHES = 512;

   localparam int PATCH_WIDTH = DATA_WIDTH * PATCH_SIZE;
   localparam int INDEX_WIDTH = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   typedef logic [PATCH_WIDTH-1:0] patch_t;

endpackage

// File: rtl/query_patch_loader_packer.sv
// Collects PATCH_SIZE accepted pixels into an assembly buffer and presents the
// finished patch (final pixel merged in) together with a one-cycle completion pulse.
module patch_packer
   import query_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [DATA_WIDTH-1:0] pixel,
   output patch_t                patch,
   output logic                  patch_complete
);

   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(PATCH_SIZE - 1);

   logic [INDEX_WIDTH-1:0] pixel_index;
   logic [DATA_WIDTH-1:0]  slots [PATCH_SIZE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_index <= '0;
         for (int k = 0; k < PATCH_SIZE; k++) begin
            slots[k] <= '0;
         end
      end else if (clear) begin
         pixel_index <= '0;
      end else if (accept) begin
         for (int k = 0; k < PATCH_SIZE; k++) begin
            if (pixel_index == INDEX_WIDTH'(k)) begin
               slots[k] <= pixel;
            end
         end
         if (pixel_index == LAST_INDEX) begin
            pixel_index <= '0;
         end else begin
            pixel_index <= pixel_index + 1'b1;
         end
      end
   end

   assign patch_complete = accept && (pixel_index == LAST_INDEX);

   // The final pixel bypasses the buffer so the patch can be written the very next cycle.
   always_comb begin
      patch = '0;
      for (int k = 0; k < PATCH_SIZE; k++) begin
         if (patch_complete && (pixel_index == INDEX_WIDTH'(k))) begin
            patch[k*DATA_WIDTH +: DATA_WIDTH] = pixel;
         end else begin
            patch[k*DATA_WIDTH +: DATA_WIDTH] = slots[k];
         end
      end
   end

endmodule

// File: rtl/query_patch_loader.sv
// Streams query pixels into patches and writes each finished patch into SRAM port 0
// at sequential addresses; one load covers NUM_PATCHES patches.
module query_patch_loader
   import query_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             in_valid,
   input  logic [DATA_WIDTH-1:0]            in_data,
   output logic                             in_ready,
   output logic                             csb0,
   output logic                             web0,
   output logic [ADDR_WIDTH-1:0]            addr0,
   output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
   output logic                             busy,
   output logic                             done,
   output logic [ADDR_WIDTH:0]              patch_count
);

   localparam logic [ADDR_WIDTH:0] LAST_PATCH = (ADDR_WIDTH + 1)'(NUM_PATCHES - 1);

   loader_state_t state;
   logic          launch;
   logic          accept;
   logic          patch_complete;
   logic          last_patch;
   patch_t        patch;

   assign launch     = start && ((state == IDLE) || (state == DONE));
   assign in_ready   = (state == LOAD);
   assign accept     = in_valid && in_ready;
   assign busy       = (state == LOAD) || (state == FLUSH);
   assign done       = (state == DONE);
   assign last_patch = patch_complete && (patch_count == LAST_PATCH);

   patch_packer u_packer (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (launch),
      .accept         (accept),
      .pixel          (in_data),
      .patch          (patch),
      .patch_complete (patch_complete)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (launch) state <= LOAD;
            LOAD:    if (last_patch) state <= FLUSH;
            FLUSH:   state <= DONE;
            DONE:    if (launch) state <= LOAD;
            default: state <= IDLE;
         endcase
      end
   end

   // The write register drains every cycle; patch_count doubles as the write address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csb0        <= 1'b1;
         web0        <= 1'b1;
         addr0       <= '0;
         wpatch0     <= '0;
         patch_count <= '0;
      end else begin
         csb0 <= ~patch_complete;
         web0 <= ~patch_complete;
         if (launch) begin
            patch_count <= '0;
         end else if (patch_complete) begin
            addr0       <= patch_count[ADDR_WIDTH-1:0];
            wpatch0     <= patch;
            patch_count <= patch_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_query_patch_loader.sv
// Randomized bench for query_patch_loader: a cycle-level transaction model predicts
// every output; an SRAM model on port 0 is compared with the golden packed image.
module tb_query_patch_loader;

   localparam int DW = 11;
   localparam int PS = 5;
   localparam int NP = 512;
   localparam int PW = DW * PS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          csb0;
   logic          web0;
   logic [8:0]    addr0;
   logic [PW-1:0] wpatch0;
   logic          busy;
   logic          done;
   logic [9:0]    patch_count;

   int passCount  = 0;
   int checkCount = 0;
   bit stuck      = 0;

   logic [PW-1:0] mem [NP];
   int            writesSeen = 0;
   int            lastAddr   = -1;

   int            phase      = 0;
   int            writes     = 0;
   int            expCount   = 0;
   bit            writeDue   = 0;
   int            dueAddr    = 0;
   logic [PW-1:0] duePatch   = '0;
   logic [DW-1:0] pixQ [$];

   query_patch_loader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .csb0        (csb0),
      .web0        (web0),
      .addr0       (addr0),
      .wpatch0     (wpatch0),
      .busy        (busy),
      .done        (done),
      .patch_count (patch_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [PW-1:0] packQueue();
      logic [PW-1:0] p;
      p = '0;
      for (int k = 0; k < PS; k++) begin
         p[k*DW +: DW] = pixQ[k];
      end
      return p;
   endfunction

   function automatic logic [PW-1:0] goldenPatch(input int p);
      logic [PW-1:0] g;
      g = '0;
      for (int k = 0; k < PS; k++) begin
         g[k*DW +: DW] = DW'((p * PS + k) % 2048);
      end
      return g;
   endfunction

   // Transaction-level model: a load accepts pixels while active, every fifth pixel
   // produces one write on the following cycle, and the load ends after NP patches.
   always @(negedge clk) begin
      int nextPhase;
      if (!rst_n) begin
         checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
         checkOutput("rst_csb0", 64'(csb0), 64'(1));
         checkOutput("rst_web0", 64'(web0), 64'(1));
         checkOutput("rst_busy", 64'(busy), 64'(0));
         checkOutput("rst_done", 64'(done), 64'(0));
         checkOutput("rst_patch_count", 64'(patch_count), 64'(0));
         phase    = 0;
         writes   = 0;
         expCount = 0;
         writeDue = 0;
         pixQ.delete();
      end else begin
         checkOutput("in_ready", 64'(in_ready), 64'(phase == 1));
         checkOutput("busy", 64'(busy), 64'((phase == 1) || (phase == 2)));
         checkOutput("done", 64'(done), 64'(phase == 3));
         checkOutput("write_strobe", 64'({csb0, web0}), writeDue ? 64'(0) : 64'(3));
         checkOutput("patch_count", 64'(patch_count), 64'(expCount));
         if (!csb0 && !web0) begin
            mem[addr0] = wpatch0;
            writesSeen++;
            lastAddr = int'(addr0);
         end
         if (writeDue) begin
            checkOutput("addr0", 64'(addr0), 64'(dueAddr));
            checkOutput("wpatch0", 64'(wpatch0), 64'(duePatch));
         end
         nextPhase = phase;
         writeDue  = 0;
         if (phase == 1 && in_valid) begin
            pixQ.push_back(in_data);
            if (pixQ.size() == PS) begin
               duePatch = packQueue();
               dueAddr  = writes;
               writes++;
               expCount = writes;
               writeDue = 1;
               pixQ.delete();
               if (writes == NP) nextPhase = 2;
            end
         end else if (phase == 2) begin
            nextPhase = 3;
         end
         if (start && (phase == 0 || phase == 3)) begin
            nextPhase = 1;
            writes    = 0;
            expCount  = 0;
            pixQ.delete();
         end
         phase = nextPhase;
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic applyStimulus(input logic [DW-1:0] value, input bit gaps);
      bit accepted;
      int waitCycles;
      if (stuck) return;
      if (gaps) begin
         for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            @(posedge clk); #1;
         end
      end
      in_valid   = 1'b1;
      in_data    = value;
      accepted   = 0;
      waitCycles = 0;
      while (!accepted && waitCycles < 50) begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk); #1;
         waitCycles++;
      end
      if (!accepted) begin
         checkOutput("accept_timeout", 64'(0), 64'(1));
         stuck = 1;
      end
   endtask

   task automatic waitDone();
      int cycles;
      in_valid = 1'b0;
      cycles   = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!done && cycles < 20);
      checkOutput("done_seen", 64'(done), 64'(1));
      checkOutput("idle_in_ready", 64'(in_ready), 64'(0));
      checkOutput("final_count", 64'(patch_count), 64'(NP));
      @(posedge clk); #1;
   endtask

   task automatic compareImage(input string tag);
      for (int p = 0; p < NP; p++) begin
         checkOutput(tag, 64'(mem[p]), 64'(goldenPatch(p)));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      foreach (mem[i]) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First patch: pixels 1..5
      pulseStart();
      for (int i = 1; i <= PS; i++) applyStimulus(DW'(i), 0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("first_write_count", 64'(writesSeen), 64'(1));
      checkOutput("first_addr", 64'(lastAddr), 64'(0));
      checkOutput("first_patch", 64'(mem[0]), 64'({11'd5, 11'd4, 11'd3, 11'd2, 11'd1}));

      // start while loading must be ignored
      pulseStart();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("count_after_ignored_start", 64'(patch_count), 64'(1));
      checkOutput("busy_after_ignored_start", 64'(busy), 64'(1));

      // Patches 1..6 plus three pixels of patch 7, then reset
      for (int i = 0; i < 6 * PS + 3; i++) applyStimulus(DW'($urandom), 0);
      in_valid = 1'b0;
      checkOutput("count_before_reset", 64'(patch_count), 64'(7));
      rst_n = 1'b0;
      #1;
      checkOutput("async_in_ready", 64'(in_ready), 64'(0));
      checkOutput("async_csb0", 64'(csb0), 64'(1));
      checkOutput("async_web0", 64'(web0), 64'(1));
      checkOutput("async_addr0", 64'(addr0), 64'(0));
      checkOutput("async_wpatch0", 64'(wpatch0), 64'(0));
      checkOutput("async_busy", 64'(busy), 64'(0));
      checkOutput("async_done", 64'(done), 64'(0));
      checkOutput("async_patch_count", 64'(patch_count), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full gap-free load after the reset
      foreach (mem[i]) mem[i] = '0;
      writesSeen = 0;
      pulseStart();
      for (int i = 0; i < NP * PS; i++) applyStimulus(DW'(i % 2048), 0);
      waitDone();
      checkOutput("continuous_writes", 64'(writesSeen), 64'(NP));
      compareImage("continuous_image");

      // Restart from DONE, then a full load with random valid gaps
      foreach (mem[i]) mem[i] = '0;
      writesSeen = 0;
      pulseStart();
      checkOutput("done_falls", 64'(done), 64'(0));
      checkOutput("restart_count", 64'(patch_count), 64'(0));
      for (int i = 0; i < NP * PS; i++) applyStimulus(DW'(i % 2048), 1);
      waitDone();
      checkOutput("gapped_writes", 64'(writesSeen), 64'(NP));
      compareImage("gapped_image");

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
